// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder: one 4-bit ripple slice walks the operands a nibble per
// cycle, LSB first, with the carry held in a register between nibbles.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES,
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   sum,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W:0]       sum_q, sum_d;
    logic [4:0]       nib_res;

    // 5-bit result of one slice: {carry_out, nibble_sum}
    function automatic logic [4:0] nib_add(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       cin);
        return {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        nib_res = nib_add(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], carry_q);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[4*idx_q +: 4] = nib_res[3:0];
                carry_d             = nib_res[4];
                if (idx_q == IDX_LAST) begin
                    sum_d[W] = nib_res[4];
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // Handshake outputs depend on state only, so no combinational in->out path
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign sum       = sum_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl with NIBBLES=4: expected sums
// are queued at the accept edge and compared when the result is presented.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W:0]   sum;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;
    logic [W:0] exp_q[$];

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present a pair, wait (bounded) for in_ready, and queue the expected sum at the accept edge
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
        int k;
        a = av;
        b = bv;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 30) begin
            cycle();
            k++;
        end
        @(posedge clk);
        exp_q.push_back({1'b0, av} + {1'b0, bv});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cycle();
        vectors++;
        if ({in_ready, out_valid, busy, sum} !== {1'b1, 1'b0, 1'b0, {(W+1){1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_hold: rdy/vld/busy/sum=%b%b%b/%h expected 100/00000",
                     in_ready, out_valid, busy, sum);
        end
        reset = 1'b0;
        cycle();
        vectors++;
        if ({in_ready, out_valid, busy, sum} !== {1'b1, 1'b0, 1'b0, {(W+1){1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_release: rdy/vld/busy/sum=%b%b%b/%h expected 100/00000",
                     in_ready, out_valid, busy, sum);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [W:0] e;
        out_ready = 1'b1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ready_pre: in_ready=%b expected 1", in_ready);
        end
        send(16'h1234, 16'h4321);
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_run: busy=%b in_ready=%b expected 1 0", busy, in_ready);
        end
        wait_out(n);
        vectors++;
        if (n != NIBBLES) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles expected %0d", n, NIBBLES);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        vectors++;
        if (sum !== e || e !== 17'h05555) begin
            miscompares++;
            $display("FAIL basic_sum: sum=%h expected %h (05555)", sum, e);
        end
        cycle();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_return: rdy/vld/busy=%b%b%b expected 100",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_carry_chain();
        int n;
        logic [W:0] e;
        out_ready = 1'b1;
        send(16'hFFFF, 16'h0001);
        for (int i = 0; i < NIBBLES; i++) begin
            cycle();
            vectors++;
            if (dut.carry_q !== 1'b1) begin
                miscompares++;
                $display("FAIL carry_nib%0d: carry=%b expected 1", i, dut.carry_q);
            end
        end
        wait_out(n);
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL carry_latency: out_valid %0d cycles late", n);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        vectors++;
        if (sum !== e || e !== 17'h10000) begin
            miscompares++;
            $display("FAIL carry_sum: sum=%h expected %h (10000)", sum, e);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        int n;
        logic [W:0] e;
        out_ready = 1'b0;
        send(16'h8000, 16'h8000);
        wait_out(n);
        vectors++;
        if (n != NIBBLES) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d cycles expected %0d", n, NIBBLES);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        for (int i = 0; i < 10; i++) begin
            a = 16'h1111 + 16'(i);
            b = 16'h2222;
            in_valid = 1'b1;
            cycle();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
                sum !== e || e !== 17'h10000) begin
                miscompares++;
                $display("FAIL bp_hold%0d: vld/rdy/busy/sum=%b%b%b/%h expected 101/%h",
                         i, out_valid, in_ready, busy, sum, e);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: rdy/vld/busy=%b%b%b expected 100",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        logic [W:0] e;
        out_ready = 1'b1;
        send(16'h00FF, 16'h00FF);
        repeat (2) cycle();
        reset = 1'b1;
        #1;
        vectors++;
        if ({in_ready, out_valid, busy, sum} !== {1'b1, 1'b0, 1'b0, {(W+1){1'b0}}}) begin
            miscompares++;
            $display("FAIL rst_async: rdy/vld/busy/sum=%b%b%b/%h expected 100/00000",
                     in_ready, out_valid, busy, sum);
        end
        exp_q.delete();
        reset = 1'b0;
        cycle();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_no_result: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        send(16'h0001, 16'h0002);
        wait_out(n);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        vectors++;
        if (n != NIBBLES || sum !== e || e !== 17'h00003) begin
            miscompares++;
            $display("FAIL rst_after: lat=%0d sum=%h expected lat %0d sum %h (00003)",
                     n, sum, NIBBLES, e);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int acc2;
        int ov_cnt;
        bit pend;
        logic [W:0] e;
        out_ready = 1'b1;
        acc2 = 0;
        ov_cnt = 0;
        pend = 1'b0;
        a = 16'h0F0F;
        b = 16'h0101;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back({1'b0, 16'h0F0F} + {1'b0, 16'h0101});
        #1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        for (int k = 1; k <= 16; k++) begin
            cycle();
            if (pend) begin
                in_valid = 1'b0;
                pend = 1'b0;
                acc2 = k;
                exp_q.push_back({1'b0, 16'hFFFF} + {1'b0, 16'hFFFF});
            end
            if (out_valid) begin
                ov_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_extra: unexpected result sum=%h at cycle %0d", sum, k);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e) begin
                        miscompares++;
                        $display("FAIL b2b_sum: sum=%h expected %h at cycle %0d", sum, e, k);
                    end
                end
            end
            if (in_ready && in_valid && acc2 == 0) pend = 1'b1;
        end
        in_valid = 1'b0;
        vectors++;
        if (acc2 != NIBBLES + 2) begin
            miscompares++;
            $display("FAIL b2b_interval: second accept %0d cycles after first, expected %0d",
                     acc2, NIBBLES + 2);
        end
        vectors++;
        if (ov_cnt != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: %0d result cycles, %0d pending, expected 2 and 0",
                     ov_cnt, exp_q.size());
        end
    endtask

    task automatic test_zero();
        int n;
        logic [W:0] e;
        out_ready = 1'b1;
        send(16'h0000, 16'h0000);
        wait_out(n);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        vectors++;
        if (n != NIBBLES) begin
            miscompares++;
            $display("FAIL zero_latency: got %0d cycles expected %0d", n, NIBBLES);
        end
        vectors++;
        if (sum !== e || e !== 17'h00000) begin
            miscompares++;
            $display("FAIL zero_sum: sum=%h expected %h (00000)", sum, e);
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
